// File: rtl/gate_tt_checker_if.sv
// Handshake and gate-facing signals between the truth-table checker and its environment.
// The master modport is the checker; the slave modport is the bench/gate side.
interface gate_tt_checker_if;
  logic       start;
  logic [2:0] func_sel;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [2:0] err_count;

  modport master (
    input  start, func_sel, y,
    output a, b, busy, done, pass, fail_mask, err_count
  );

  modport slave (
    output start, func_sel, y,
    input  a, b, busy, done, pass, fail_mask, err_count
  );
endinterface

// File: rtl/gate_tt_checker.sv
// Sweeps a 2-input gate through all four {a,b} vectors, samples y after a settle window,
// and records per-vector mismatches against the selected truth table.
module gate_tt_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SETTLE_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  gate_tt_checker_if.master   tt
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_e;

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  state_e            state_q;
  logic [1:0]        vec_q;
  logic [SETTLE_W-1:0] cnt_q;
  logic [2:0]        func_q;
  logic              a_q, b_q, busy_q, done_q, pass_q;
  logic [3:0]        mask_q;
  logic [2:0]        err_q;

  logic exp_y;
  logic mism;

  // Expected response uses the driven (registered) a/b, not vec, so it matches what the gate saw.
  always_comb begin
    exp_y = 1'b0;
    case (func_q)
      3'd0: exp_y = a_q & b_q;
      3'd1: exp_y = a_q | b_q;
      3'd2: exp_y = ~(a_q & b_q);
      3'd3: exp_y = ~(a_q | b_q);
      3'd4: exp_y = a_q ^ b_q;
      3'd5: exp_y = ~(a_q ^ b_q);
      3'd6: exp_y = ~a_q;
      3'd7: exp_y = a_q;
      default: exp_y = 1'b0;
    endcase
  end

  assign mism = (tt.y != exp_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      func_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          a_q <= 1'b0;
          b_q <= 1'b0;
          if (tt.start) begin
            func_q  <= tt.func_sel;
            mask_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          a_q     <= vec_q[1];
          b_q     <= vec_q[0];
          cnt_q   <= SETTLE_LOAD;
          state_q <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SETTLE_W'(1)) state_q <= SAMPLE;
        end
        SAMPLE: begin
          if (mism) begin
            mask_q[vec_q] <= 1'b1;
            err_q         <= err_q + 3'd1;
          end
          if (vec_q == 2'd3) begin
            // Final vector's verdict folds into pass on the same edge it is recorded.
            pass_q  <= (err_q == 3'd0) && !mism;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            vec_q   <= vec_q + 2'd1;
            state_q <= DRIVE;
          end
        end
        DONE: begin
          a_q     <= 1'b0;
          b_q     <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tt.a         = a_q;
  assign tt.b         = b_q;
  assign tt.busy      = busy_q;
  assign tt.done      = done_q;
  assign tt.pass      = pass_q;
  assign tt.fail_mask = mask_q;
  assign tt.err_count = err_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Randomized bench for gate_tt_checker: two instances (settle 2 and settle 0) driven by
// table-based fake gates, checked against truth tables and the sweep timing formula.
module tb_gate_tt_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_tt_checker_if if0 ();
  gate_tt_checker_if if1 ();

  logic [3:0] ytab0 = 4'd0;
  logic [3:0] ytab1 = 4'd0;

  assign if0.y = ytab0[{if0.a, if0.b}];
  assign if1.y = ytab1[{if1.a, if1.b}];

  gate_tt_checker #(.SETTLE_CYCLES(2), .SETTLE_W(4)) u_dut0 (.clk(clk), .rst(rst), .tt(if0));
  gate_tt_checker #(.SETTLE_CYCLES(0), .SETTLE_W(4)) u_dut1 (.clk(clk), .rst(rst), .tt(if1));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Truth table indexed by {a,b}: bit i is the gate output for a=i[1], b=i[0].
  function automatic logic [3:0] tt_of(input logic [2:0] fn);
    logic [3:0] t;
    logic [1:0] ab;
    t = '0;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      case (fn)
        3'd0: t[i] = ab[1] & ab[0];
        3'd1: t[i] = ab[1] | ab[0];
        3'd2: t[i] = !(ab[1] & ab[0]);
        3'd3: t[i] = !(ab[1] | ab[0]);
        3'd4: t[i] = ab[1] ^ ab[0];
        3'd5: t[i] = !(ab[1] ^ ab[0]);
        3'd6: t[i] = !ab[1];
        default: t[i] = ab[1];
      endcase
    end
    return t;
  endfunction

  function automatic int popc(input logic [3:0] m);
    return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
  endfunction

  // Packed snapshot: {a,b,busy,done,pass,mask[3:0],err[2:0]}
  task automatic rd(input int inst, output logic [11:0] v);
    if (inst == 0) v = {if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.fail_mask, if0.err_count};
    else           v = {if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.fail_mask, if1.err_count};
  endtask

  task automatic drv(input int inst, input logic st, input logic [2:0] fs);
    if (inst == 0) begin if0.start = st; if0.func_sel = fs; end
    else           begin if1.start = st; if1.func_sel = fs; end
  endtask

  task automatic set_tab(input int inst, input logic [3:0] t);
    if (inst == 0) ytab0 = t; else ytab1 = t;
  endtask

  task automatic chk_idle(input int inst, input string tag);
    logic [11:0] v;
    rd(inst, v);
    chk({tag, ".ab"},   32'(v[11:10]), 32'd0);
    chk({tag, ".busy"}, 32'(v[9]),     32'd0);
    chk({tag, ".done"}, 32'(v[8]),     32'd0);
    chk({tag, ".pass"}, 32'(v[7]),     32'd0);
    chk({tag, ".mask"}, 32'(v[6:3]),   32'd0);
    chk({tag, ".err"},  32'(v[2:0]),   32'd0);
  endtask

  // Run one sweep; called at a negedge with the DUT idle. abort_k>0 asserts reset in that cycle.
  task automatic sweep(input int inst, input logic [2:0] fn, input logic [3:0] tab,
                       input bit disturb, input int abort_k);
    int per, len, v, p, cur;
    logic [11:0] snap;
    logic [3:0] emask;
    per = (inst == 0) ? 4 : 2;
    len = 4 * per;
    emask = tab ^ tt_of(fn);
    set_tab(inst, tab);
    drv(inst, 1'b1, fn);
    @(posedge clk);
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge clk);
      if (k == 1) drv(inst, 1'b0, fn);
      if (disturb && k >= 2 && k < len) drv(inst, 1'($urandom_range(1)), 3'($urandom));
      if (k >= len) drv(inst, 1'b0, fn);
      if (abort_k == k) begin
        rst = 1'b1;
        #1;
        chk_idle(inst, "rst_mid");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      rd(inst, snap);
      if (k <= len) begin
        v = (k - 1) / per;
        p = (k - 1) % per;
        cur = (p >= 1) ? v : ((v == 0) ? 0 : v - 1);
        chk("ab",   32'(snap[11:10]), 32'(cur));
        chk("busy", 32'(snap[9]),     32'd1);
        chk("done", 32'(snap[8]),     32'd0);
      end else if (k == len + 1) begin
        chk("done_ab",   32'(snap[11:10]), 32'd3);
        chk("done_busy", 32'(snap[9]),     32'd0);
        chk("done",      32'(snap[8]),     32'd1);
        chk("pass",      32'(snap[7]),     32'(emask == 4'd0));
        chk("mask",      32'(snap[6:3]),   32'(emask));
        chk("err",       32'(snap[2:0]),   32'(popc(emask)));
      end else begin
        chk("post_ab",   32'(snap[11:10]), 32'd0);
        chk("post_done", 32'(snap[8]),     32'd0);
        chk("post_busy", 32'(snap[9]),     32'd0);
        chk("hold_pass", 32'(snap[7]),     32'(emask == 4'd0));
        chk("hold_mask", 32'(snap[6:3]),   32'(emask));
        chk("hold_err",  32'(snap[2:0]),   32'(popc(emask)));
      end
    end
    // Extra idle cycle: a stray start must not have re-launched a sweep.
    @(negedge clk);
    rd(inst, snap);
    chk("idle_busy", 32'(snap[9]), 32'd0);
  endtask

  initial begin
    logic [2:0] fn;
    logic [3:0] tab;
    drv(0, 1'b0, 3'd0);
    drv(1, 1'b0, 3'd0);
    repeat (3) @(negedge clk);
    chk_idle(0, "reset0");
    chk_idle(1, "reset1");
    rst = 1'b0;
    @(negedge clk);

    sweep(0, 3'd3, tt_of(3'd3), 1'b0, 0);      // correct NOR
    sweep(0, 3'd3, 4'b0000, 1'b0, 0);          // y tied 0
    sweep(0, 3'd4, 4'b1000, 1'b0, 0);          // XOR expected, AND observed
    sweep(0, 3'd3, tt_of(3'd3) ^ 4'b0001, 1'b0, 10); // reset in SETTLE of vector 2
    sweep(0, 3'd5, tt_of(3'd5), 1'b0, 0);      // fresh sweep after reset
    sweep(0, 3'd3, tt_of(3'd3), 1'b1, 0);      // start/func_sel noise mid-sweep
    sweep(1, 3'd1, tt_of(3'd1), 1'b0, 0);      // zero settle, correct OR

    for (int r = 0; r < 16; r++) begin
      fn  = 3'($urandom);
      tab = ($urandom_range(1) == 0) ? tt_of(fn) : 4'($urandom);
      sweep(r % 2, fn, tab, 1'($urandom_range(1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
